// File: rtl/arm_ctrl_pkg.sv
// Shared control definitions for the multi-cycle ARM control path:
// state encoding, ALU command codes, datapath select encodings, Op field values.
package arm_ctrl_pkg;

    // Main controller states (4-bit, visible on the State debug output).
    // ST_MULWT is the multiplier-busy continuation of ST_MULEX; it lets
    // MulStart be a single-cycle pulse while the state register stays the
    // only sequential element.
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWR  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_EXECR  = 4'd6,
        ST_EXECI  = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_MULEX  = 4'd10,
        ST_MULWT  = 4'd11
    } state_t;

    // ALU commands, identical to the data-processing cmd field.
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_RSB = 4'b0011;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ADC = 4'b0101;
    localparam logic [3:0] CMD_SBC = 4'b0110;
    localparam logic [3:0] CMD_RSC = 4'b0111;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_TEQ = 4'b1001;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_BIC = 4'b1110;
    localparam logic [3:0] CMD_MVN = 4'b1111;

    // ALU operand A select.
    localparam logic [1:0] SRCA_RD1 = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    // ALU operand B select.
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_EXT  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select.
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_READ   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_MUL    = 2'b11;

    // Instruction class (Instr[27:26]).
    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    // Multiply encoding: Instr[27:22]=0 and Instr[7:4]=1001.
    function automatic logic is_mul_pattern(input logic [31:0] instr);
        return (instr[27:22] == 6'b000000) && (instr[7:4] == 4'b1001);
    endfunction

    // Commands whose C/V result is meaningful (adder-based).
    function automatic logic is_arith(input logic [3:0] cmd);
        logic r;
        r = 1'b0;
        case (cmd)
            CMD_SUB, CMD_RSB, CMD_ADD, CMD_ADC,
            CMD_SBC, CMD_RSC, CMD_CMP, CMD_CMN: r = 1'b1;
            CMD_AND, CMD_EOR, CMD_TST, CMD_TEQ,
            CMD_ORR, CMD_MOV, CMD_BIC, CMD_MVN: r = 1'b0;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control interface between the main controller (master) and the
// datapath / conditional-execution side (slave).
// Handshake: there is no valid/ready pair; every output is a combinational
// function of State, Instr and MemReady and is valid every cycle. Memory
// accesses (fetch, read, write) complete on a rising CLK edge where
// MemReady=1, and all outputs stay stable while MemReady=0.
interface mc_ctrl_fsm_if;
    logic [31:0] Instr;
    logic        MemReady;
    logic        MulDone;
    logic        PCS;
    logic        RegW;
    logic        MemW;
    logic [1:0]  FlagW;
    logic        NoWrite;
    logic        IRWrite;
    logic        NextPC;
    logic        AdrSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [3:0]  ALUControl;
    logic        MulStart;
    logic [3:0]  State;

    modport master (
        input  Instr, MemReady, MulDone,
        output PCS, RegW, MemW, FlagW, NoWrite, IRWrite, NextPC, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, MulStart, State
    );

    modport slave (
        output Instr, MemReady, MulDone,
        input  PCS, RegW, MemW, FlagW, NoWrite, IRWrite, NextPC, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, MulStart, State
    );
endinterface

// File: rtl/dp_field_decode.sv
// Data-processing field decode: cmd/S bits -> ALUControl, FlagW, NoWrite.
// Multiplies are forced to a neutral ALU command and never update C/V.
module dp_field_decode
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cmd,
    input  logic       s,
    input  logic       is_mul,
    output logic [3:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write
);

    // Pure decode of the function field.
    always_comb begin
        alu_control = cmd;
        flag_w      = 2'b00;
        no_write    = 1'b0;
        if (is_mul) begin
            alu_control = CMD_AND;
            flag_w      = {s, 1'b0};
            no_write    = 1'b0;
        end else begin
            alu_control = cmd;
            flag_w      = {s, s & is_arith(cmd)};
            no_write    = (cmd[3:2] == 2'b10);
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main control FSM: fetch / decode / execute / memory / writeback
// sequencing and datapath select generation.
// Optional feature: define MUL_EN to enable the MULEX multiply path
// (MulStart pulse, MulDone wait, ResultSrc=MulResult on writeback).
module mc_ctrl_fsm
    import arm_ctrl_pkg::*;
(
    input  logic          CLK,
    input  logic          Reset_n,
    mc_ctrl_fsm_if.master bus
);

    state_t      state_q;
    state_t      state_n;

    logic [31:0] instr;
    logic        mem_ready;
    logic        mul_done;
    logic [1:0]  op;
    logic        imm;
    logic [3:0]  cmd;
    logic        s_bit;
    logic        u_bit;
    logic        rd_pc;
    logic        is_mul;

    logic [3:0]  dp_alu_control;
    logic [1:0]  dp_flag_w;
    logic        dp_no_write;

    logic        pcs;
    logic        reg_w;
    logic        mem_w;
    logic [1:0]  flag_w;
    logic        no_write;
    logic        ir_write;
    logic        next_pc;
    logic        adr_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [3:0]  alu_control;
    logic        mul_start;

    logic        unused_ok;

    assign instr     = bus.Instr;
    assign mem_ready = bus.MemReady;
    assign mul_done  = bus.MulDone;
    assign op        = instr[27:26];
    assign imm       = instr[25];
    assign cmd       = instr[24:21];
    assign s_bit     = instr[20];
    assign u_bit     = instr[23];
    assign rd_pc     = (instr[15:12] == 4'hF);

`ifdef MUL_EN
    assign is_mul = is_mul_pattern(instr);
`else
    assign is_mul = 1'b0;
`endif

    // Instruction bits the controller never looks at, and MulDone in builds
    // without the multiplier.
    assign unused_ok = ^{instr[31:28], instr[19:16], instr[11:0], mul_done};

    dp_field_decode u_dp_field_decode (
        .cmd         (cmd),
        .s           (s_bit),
        .is_mul      (is_mul),
        .alu_control (dp_alu_control),
        .flag_w      (dp_flag_w),
        .no_write    (dp_no_write)
    );

    // State register; reset forces FETCH immediately.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) state_q <= ST_FETCH;
        else          state_q <= state_n;
    end

    // Next-state selection.
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_n = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_MEM: state_n = ST_MEMADR;
                    OP_BR:  state_n = ST_BRANCH;
                    OP_DP: begin
                        if (imm) state_n = ST_EXECI;
                        else     state_n = ST_EXECR;
`ifdef MUL_EN
                        if (is_mul) state_n = ST_MULEX;
`endif
                    end
                    default: state_n = ST_FETCH;
                endcase
            end
            ST_MEMADR: state_n = s_bit ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (mem_ready) state_n = ST_MEMWB;
            ST_MEMWR:  if (mem_ready) state_n = ST_FETCH;
            ST_MEMWB:  state_n = ST_FETCH;
            ST_EXECR:  state_n = ST_ALUWB;
            ST_EXECI:  state_n = ST_ALUWB;
            ST_ALUWB:  state_n = ST_FETCH;
            ST_BRANCH: state_n = ST_FETCH;
`ifdef MUL_EN
            ST_MULEX:  state_n = mul_done ? ST_ALUWB : ST_MULWT;
            ST_MULWT:  if (mul_done) state_n = ST_ALUWB;
`endif
            default:   state_n = ST_FETCH;
        endcase
    end

    // Per-state datapath selects and write requests.
    always_comb begin
        pcs         = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        flag_w      = 2'b00;
        no_write    = 1'b0;
        ir_write    = 1'b0;
        next_pc     = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = SRCA_RD1;
        alu_src_b   = SRCB_RD2;
        result_src  = RES_ALUOUT;
        alu_control = CMD_AND;
        mul_start   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                alu_src_a   = SRCA_PC;
                alu_src_b   = SRCB_FOUR;
                alu_control = CMD_ADD;
                result_src  = RES_ALURES;
                ir_write    = mem_ready;
                next_pc     = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a   = SRCA_PC;
                alu_src_b   = SRCB_FOUR;
                alu_control = CMD_ADD;
            end
            ST_MEMADR, ST_MEMRD, ST_MEMWR: begin
                alu_src_a   = SRCA_RD1;
                alu_src_b   = SRCB_EXT;
                alu_control = u_bit ? CMD_ADD : CMD_SUB;
                adr_src     = 1'b1;
                mem_w       = (state_q == ST_MEMWR);
            end
            ST_MEMWB: begin
                result_src = RES_READ;
                reg_w      = 1'b1;
                pcs        = rd_pc;
            end
            ST_EXECR, ST_EXECI: begin
                alu_src_a   = SRCA_RD1;
                alu_src_b   = (state_q == ST_EXECI) ? SRCB_EXT : SRCB_RD2;
                alu_control = dp_alu_control;
            end
            ST_ALUWB: begin
                // Instr is still stable, so the EXEC selects are re-derived
                // from it rather than remembered.
                alu_src_a   = SRCA_RD1;
                alu_src_b   = (imm && !is_mul) ? SRCB_EXT : SRCB_RD2;
                alu_control = dp_alu_control;
                result_src  = is_mul ? RES_MUL : RES_ALUOUT;
                reg_w       = 1'b1;
                pcs         = rd_pc;
                no_write    = dp_no_write;
                flag_w      = dp_flag_w;
            end
            ST_BRANCH: begin
                alu_src_a   = SRCA_PC;
                alu_src_b   = SRCB_EXT;
                alu_control = CMD_ADD;
                result_src  = RES_ALURES;
                pcs         = 1'b1;
            end
`ifdef MUL_EN
            ST_MULEX, ST_MULWT: begin
                alu_control = dp_alu_control;
                mul_start   = (state_q == ST_MULEX);
            end
`endif
            default: begin
            end
        endcase
    end

    assign bus.PCS        = pcs;
    assign bus.RegW       = reg_w;
    assign bus.MemW       = mem_w;
    assign bus.FlagW      = flag_w;
    assign bus.NoWrite    = no_write;
    assign bus.IRWrite    = ir_write;
    assign bus.NextPC     = next_pc;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = alu_control;
    assign bus.MulStart   = mul_start;
    assign bus.State      = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm: per-cycle directed vectors with hand-computed
// expected output words, checked by an independent negedge monitor.
module tb_mc_ctrl_fsm;
    import arm_ctrl_pkg::*;

    localparam int W = 24;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_fsm_if bus();

    mc_ctrl_fsm dut (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    // Scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    // Expected word: {State, PCS, RegW, MemW, FlagW, NoWrite, IRWrite, NextPC,
    //                 AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, MulStart}
    function automatic logic [W-1:0] ev(
        input logic [3:0] st, input logic pcs, input logic regw, input logic memw,
        input logic [1:0] fw, input logic nw, input logic irw, input logic npc,
        input logic adr, input logic [1:0] sa, input logic [1:0] sb,
        input logic [1:0] rs, input logic [3:0] ac, input logic ms);
        return {st, pcs, regw, memw, fw, nw, irw, npc, adr, sa, sb, rs, ac, ms};
    endfunction

    function automatic logic [W-1:0] fe(input logic mr);
        return ev(4'd0, 0, 0, 0, 2'b00, 0, mr, mr, 0, 2'b01, 2'b10, 2'b10, 4'b0100, 0);
    endfunction

    function automatic logic [W-1:0] de();
        return ev(4'd1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 4'b0100, 0);
    endfunction

    // Driver: apply one cycle of inputs just after the rising edge and queue
    // the response expected for that cycle.
    task automatic step(input logic [31:0] instr, input logic mr, input logic md,
                        input logic rst, input logic [W-1:0] exp, input string nm);
        @(posedge clk);
        #1;
        rst_n        = rst;
        bus.Instr    = instr;
        bus.MemReady = mr;
        bus.MulDone  = md;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // Monitor: one output word per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] e;
        string        n;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            act = {bus.State, bus.PCS, bus.RegW, bus.MemW, bus.FlagW, bus.NoWrite,
                   bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB,
                   bus.ResultSrc, bus.ALUControl, bus.MulStart};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %06h expected %06h", n, act, e);
            end
        end
    end

    localparam logic [31:0] I_ADDS = 32'hE2921005;
    localparam logic [31:0] I_CMP  = 32'hE1500001;
    localparam logic [31:0] I_LDR  = 32'hE5143008;
    localparam logic [31:0] I_STR  = 32'hE5843008;
    localparam logic [31:0] I_B    = 32'hEA000000;
    localparam logic [31:0] I_UND  = 32'hEC000000;
    localparam logic [31:0] I_MOVP = 32'hE1A0F001;
    localparam logic [31:0] I_EORS = 32'hE0321003;
    localparam logic [31:0] I_MUL  = 32'hE0000291;

    initial begin
        bus.Instr    = 32'h0;
        bus.MemReady = 1'b0;
        bus.MulDone  = 1'b0;

        // Reset, then release with MemReady=1: one fetch cycle, then DECODE.
        step(32'h0,  0, 0, 0, fe(0), "reset_fetch");
        step(I_ADDS, 1, 0, 1, fe(1), "adds_fetch");
        step(I_ADDS, 1, 0, 1, de(), "adds_decode");
        step(I_ADDS, 1, 0, 1, ev(4'd7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'b0100, 0), "adds_execi");
        step(I_ADDS, 1, 0, 1, ev(4'd8, 0, 1, 0, 2'b11, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'b0100, 0), "adds_aluwb");

        // CMP R0,R1
        step(I_CMP, 1, 0, 1, fe(1), "cmp_fetch");
        step(I_CMP, 1, 0, 1, de(), "cmp_decode");
        step(I_CMP, 1, 0, 1, ev(4'd6, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b1010, 0), "cmp_execr");
        step(I_CMP, 1, 0, 1, ev(4'd8, 0, 1, 0, 2'b11, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b1010, 0), "cmp_aluwb");

        // LDR R3,[R4,#-8] with one fetch wait and three MEMRD waits
        step(I_LDR, 0, 0, 1, fe(0), "ldr_fetch_wait");
        step(I_LDR, 1, 0, 1, fe(1), "ldr_fetch");
        step(I_LDR, 1, 0, 1, de(), "ldr_decode");
        step(I_LDR, 1, 0, 1, ev(4'd2, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00, 4'b0010, 0), "ldr_memadr");
        for (int i = 0; i < 4; i++) begin
            step(I_LDR, (i == 3), 0, 1, ev(4'd3, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00, 4'b0010, 0), "ldr_memrd");
        end
        step(I_LDR, 1, 0, 1, ev(4'd5, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 4'b0000, 0), "ldr_memwb");

        // Branch: 3 cycles
        step(I_B, 1, 0, 1, fe(1), "b_fetch");
        step(I_B, 1, 0, 1, de(), "b_decode");
        step(I_B, 1, 0, 1, ev(4'd9, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 2'b10, 4'b0100, 0), "b_branch");

        // Undefined opcode: DECODE returns straight to FETCH
        step(I_UND, 1, 0, 1, fe(1), "und_fetch");
        step(I_UND, 1, 0, 1, de(), "und_decode");

        // MOV PC,R1: writeback to R15 raises PCS, logical without S
        step(I_MOVP, 1, 0, 1, fe(1), "movpc_fetch");
        step(I_MOVP, 1, 0, 1, de(), "movpc_decode");
        step(I_MOVP, 1, 0, 1, ev(4'd6, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b1101, 0), "movpc_execr");
        step(I_MOVP, 1, 0, 1, ev(4'd8, 1, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b1101, 0), "movpc_aluwb");

        // EORS: logical with S updates N/Z only
        step(I_EORS, 1, 0, 1, fe(1), "eors_fetch");
        step(I_EORS, 1, 0, 1, de(), "eors_decode");
        step(I_EORS, 1, 0, 1, ev(4'd6, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0001, 0), "eors_execr");
        step(I_EORS, 1, 0, 1, ev(4'd8, 0, 1, 0, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0001, 0), "eors_aluwb");

        // MUL R0,R1,R2
        step(I_MUL, 1, 0, 1, fe(1), "mul_fetch");
        step(I_MUL, 1, 0, 1, de(), "mul_decode");
`ifdef MUL_EN
        step(I_MUL, 1, 0, 1, ev(4'd10, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 1), "mul_mulex");
        step(I_MUL, 1, 0, 1, ev(4'd11, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 0), "mul_wait1");
        step(I_MUL, 1, 1, 1, ev(4'd11, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 0), "mul_wait2");
        step(I_MUL, 1, 0, 1, ev(4'd8, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 4'b0000, 0), "mul_aluwb");
`else
        step(I_MUL, 1, 1, 1, ev(4'd6, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 0), "mul_as_execr");
        step(I_MUL, 1, 0, 1, ev(4'd8, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 0), "mul_as_aluwb");
`endif

        // STR with reset asserted while waiting in MEMWR
        step(I_STR, 1, 0, 1, fe(1), "str_fetch");
        step(I_STR, 1, 0, 1, de(), "str_decode");
        step(I_STR, 1, 0, 1, ev(4'd2, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00, 4'b0100, 0), "str_memadr");
        step(I_STR, 0, 0, 1, ev(4'd4, 0, 0, 1, 2'b00, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00, 4'b0100, 0), "str_memwr_wait");
        step(I_STR, 0, 0, 0, fe(0), "str_reset_in_memwr");
        step(I_STR, 0, 0, 1, fe(0), "str_after_reset");

        // Drain the scoreboard
        @(posedge clk);
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle main control state machine for the ARM core: sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath selects. It also produces the raw PCS/RegW/MemW/FlagW/NoWrite requests that the conditional-execution unit gates with the condition flags. The block sits between the instruction register and the conditional-execution unit, on the producing side of that control interface.

## Interface
- No parameters.
- `CLK  in  1`: rising-edge clock.
- `Reset_n  in  1`: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `Instr  in  32`: current instruction register contents, stable from DECODE until the next FETCH completes.
- `MemReady  in  1`: memory handshake. A fetch, read or write access completes on a cycle with MemReady=1.
- `MulDone  in  1`: multiplier finished. Ignored when the `MUL_EN` macro is not defined.
- `PCS, RegW, MemW  out  1`: raw write and branch requests to the conditional-execution unit.
- `FlagW  out  2`: [1] requests an N/Z update, [0] requests a C/V update.
- `NoWrite  out  1`: compare/test instruction; suppresses the register write.
- `IRWrite, NextPC  out  1`: load the instruction register; load the PC with Result.
- `AdrSrc  out  1`: memory address source. 0 = PC, 1 = ALUOut.
- `ALUSrcA  out  2`: 00 = RD1, 01 = PC.
- `ALUSrcB  out  2`: 00 = RD2 after the shifter, 01 = ExtImm, 10 = constant 4.
- `ResultSrc  out  2`: 00 = ALUOut, 01 = ReadData, 10 = ALUResult, 11 = MulResult.
- `ALUControl  out  4`: ALU command, using the same encoding as the data-processing cmd field.
- `MulStart  out  1`: one-cycle multiplier start pulse.
- `State  out  4`: current state, for debug.

## Operation
- Field use: Op = Instr[27:26]; I = Instr[25]; cmd = Instr[24:21]; S/L = Instr[20]; U = Instr[23]; Rd = Instr[15:12].
- The state register is the only sequential element. All outputs are a combinational function of State, Instr and MemReady.
- States and transitions:
  - FETCH → DECODE when MemReady=1; otherwise stay in FETCH.
  - DECODE:
    - Op=01 → MEMADR.
    - Op=10 → BRANCH.
    - Op=00 with I=1 → EXECI.
    - Op=00 with I=0 → EXECR.
    - Op=00 with the multiply pattern (Instr[27:22]=0 and Instr[7:4]=1001) → MULEX. This path exists only when `MUL_EN` is defined.
    - Op=11 → FETCH with no writes (undefined opcode).
  - MEMADR → MEMRD if L=1, else → MEMWR.
  - MEMRD → MEMWB when MemReady=1.
  - MEMWR → FETCH when MemReady=1.
  - MEMWB → FETCH.
  - EXECR or EXECI → ALUWB. ALUWB → FETCH.
  - BRANCH → FETCH.
  - MULEX → ALUWB when MulDone=1.
- Outputs per state (any output not listed is 0):
  - FETCH: AdrSrc=0; ALUSrcA=01; ALUSrcB=10; ALUControl=ADD; ResultSrc=10; IRWrite=NextPC=MemReady.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ALUControl=ADD. This forms PC+8.
  - MEMADR, MEMRD, MEMWR: ALUSrcA=00, ALUSrcB=01, ALUControl=ADD if U=1 else SUB, AdrSrc=1. MEMWR also drives MemW=1 and holds it until MemReady=1.
  - MEMWB: ResultSrc=01; RegW=1; PCS=1 if Rd=15.
  - EXECR, EXECI: ALUSrcA=00; ALUSrcB=00 in EXECR, 01 in EXECI; ALUControl=cmd.
  - ALUWB:
    - ALU selects held exactly as in the preceding EXEC state, so operands and ALU flags stay valid.
    - ResultSrc=00, or 11 when coming from MULEX.
    - RegW=1; PCS=1 if Rd=15.
    - NoWrite=1 for cmd 1000–1011 (TST, TEQ, CMP, CMN).
    - FlagW[1]=S.
    - FlagW[0]=S for arithmetic cmds (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN); 0 for logical cmds and for MUL.
  - BRANCH: ALUSrcA=01, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCS=1.
- Flag updates, register writes and the branch request are all presented in the same cycle. The conditional-execution unit therefore evaluates the condition on the pre-instruction flags.

## Timing
- Reset: State=FETCH immediately (asynchronous). Outputs take the FETCH values above, with IRWrite=NextPC=0 until MemReady=1.
- Reset mid-instruction: the state returns to FETCH in the same cycle and MemW/RegW/FlagW drop combinationally. No partial writeback is retained.
- Cycle counts with zero wait states:
  - Data-processing: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Undefined opcode: 2 cycles.
- Each cycle of MemReady=0 adds one cycle in FETCH, MEMRD or MEMWR. Every output is held stable while waiting.
- MulStart=1 only on the first cycle in MULEX. MulDone arriving on that same cycle leaves after one cycle.

## Configuration
- `MUL_EN` defined: the MULEX state and its DECODE path exist, MulStart is driven, and MulDone is honoured.
- `MUL_EN` undefined: the multiply pattern decodes as ordinary EXECR/EXECI, MulStart is tied to 0, MulDone is unused, and ResultSrc never takes the value 11.

## Structure
- Shared package `arm_ctrl_pkg` holds:
  - the state encoding (4 bits);
  - the ALU cmd constants ADD, SUB, AND, ORR and so on;
  - the ALUSrcA, ALUSrcB and ResultSrc encodings;
  - the Op constants.
- One combinational sub-module, `dp_field_decode`: Funct bits → ALUControl, FlagW and NoWrite for the data-processing path.

## Test plan
- Reset_n low, then high with MemReady=1 → State walks FETCH→DECODE; IRWrite=NextPC=1 for exactly one cycle.
- ADDS R1,R2,#5 (Instr=0xE2921005), MemReady=1 → ALUWB in cycle 4 with RegW=1, FlagW=11, NoWrite=0, ALUSrcB=01.
- CMP R0,R1 (Instr=0xE1500001) → ALUWB with NoWrite=1, FlagW=11, RegW=1.
- LDR R3,[R4,#-8] (Instr=0xE5143008), MemReady low for 3 cycles in MEMRD → ALUControl=SUB, AdrSrc=1, MEMRD held 4 cycles, then MEMWB with ResultSrc=01.
- STR with Reset_n asserted while in MEMWR → MemW falls in the same cycle; State=FETCH.
- With `MUL_EN` defined, MUL R0,R1,R2 (Instr=0xE0000291) and MulDone after 3 cycles → one MulStart pulse, then ALUWB with ResultSrc=11, FlagW=00.
